arp_rx: RTL and testbench



---
 rtl/eth_pkg.sv | 31 +++
 rtl/arp_rx.sv | 163 ++++++++++++++++
 tb/tb_arp_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Ethernet / ARP constants shared by the receive and transmit paths.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
    localparam int unsigned ETH_HEAD_LEN   = 14;
    localparam int unsigned ARP_LEN        = 28;
    localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

    // Byte idx of a MAC address in wire order (0 = most significant).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] s;
        s = mac << {idx, 3'b000};
        return s[47:40];
    endfunction

    // Byte idx of an IPv4 address in wire order (0 = most significant).
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        logic [31:0] s;
        s = ip << {idx, 3'b000};
        return s[31:24];
    endfunction

endpackage

// File: rtl/arp_rx.sv
// Receive-side ARP parser: strips preamble/SFD, checks Ethernet + ARP headers,
// and reports opcode and sender MAC/IP of frames addressed to this board.
module arp_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_op,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ETH_HEAD,
        S_ARP_DATA,
        S_RX_END
    } state_t;

    localparam logic [5:0] ETH_LAST = 6'(ETH_HEAD_LEN - 1);
    localparam logic [5:0] ARP_LAST = 6'(ARP_LEN - 1);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic        r_dst_uc_bad;
    logic        r_dst_bc_bad;
    logic        r_err;
    logic        r_op_req;
    logic [47:0] r_sha;
    logic [31:0] r_spa;

    logic        w_uc_miss;
    logic        w_bc_miss;
    logic        w_byte_err;
    logic        w_eth_ok;
    logic        w_accept;

    // Per-byte header checks for the byte currently on gmii_rxd.
    always_comb begin
        w_uc_miss  = 1'b0;
        w_bc_miss  = 1'b0;
        w_byte_err = 1'b0;
        if (r_state == S_ETH_HEAD) begin
            if (r_cnt < 6'd6) begin
                w_uc_miss = (gmii_rxd != mac_byte(BOARD_MAC, r_cnt[2:0]));
                w_bc_miss = (gmii_rxd != MAC_BROADCAST[7:0]);
            end else if (r_cnt == 6'd12) begin
                w_byte_err = (gmii_rxd != ETH_TYPE_ARP[15:8]);
            end else if (r_cnt == 6'd13) begin
                w_byte_err = (gmii_rxd != ETH_TYPE_ARP[7:0]);
            end
        end else if (r_state == S_ARP_DATA) begin
            case (r_cnt)
                6'd0:  w_byte_err = (gmii_rxd != ARP_HTYPE_ETH[15:8]);
                6'd1:  w_byte_err = (gmii_rxd != ARP_HTYPE_ETH[7:0]);
                6'd2:  w_byte_err = (gmii_rxd != ARP_PTYPE_IPV4[15:8]);
                6'd3:  w_byte_err = (gmii_rxd != ARP_PTYPE_IPV4[7:0]);
                6'd4:  w_byte_err = (gmii_rxd != ARP_HLEN_ETH);
                6'd5:  w_byte_err = (gmii_rxd != ARP_PLEN_IPV4);
                6'd6:  w_byte_err = (gmii_rxd != ARP_OP_REQ[15:8]);
                6'd7:  w_byte_err = (gmii_rxd != ARP_OP_REQ[7:0]) && (gmii_rxd != ARP_OP_REPLY[7:0]);
                6'd24, 6'd25, 6'd26, 6'd27:
                       w_byte_err = (gmii_rxd != ip_byte(BOARD_IP, r_cnt[1:0]));
                default: w_byte_err = 1'b0;
            endcase
        end
    end

    // Destination must match on every byte of either the local or the broadcast MAC.
    assign w_eth_ok = (!r_dst_uc_bad || !r_dst_bc_bad) && !r_err && !w_byte_err;
    assign w_accept = (r_state == S_ARP_DATA) && gmii_rx_dv && (r_cnt == ARP_LAST)
                      && !r_err && !w_byte_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) w_next = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
                else if (r_cnt < 6'd6) begin
                    if (gmii_rxd != PREAMBLE_BYTE) w_next = S_RX_END;
                end else if (gmii_rxd == SFD_BYTE) w_next = S_ETH_HEAD;
                else                             w_next = S_RX_END;
            end
            S_ETH_HEAD: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
                else if (r_cnt == ETH_LAST)      w_next = w_eth_ok ? S_ARP_DATA : S_RX_END;
            end
            S_ARP_DATA: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
                else if (r_cnt == ARP_LAST)      w_next = S_RX_END;
            end
            S_RX_END: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
            end
            default:                             w_next = S_IDLE;
        endcase
    end

    // Byte counter and sticky check flags restart on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 6'd0;
            r_dst_uc_bad <= 1'b0;
            r_dst_bc_bad <= 1'b0;
            r_err        <= 1'b0;
        end else if (w_next != r_state) begin
            r_cnt        <= 6'd0;
            r_dst_uc_bad <= 1'b0;
            r_dst_bc_bad <= 1'b0;
            r_err        <= 1'b0;
        end else if (gmii_rx_dv) begin
            if (r_cnt != 6'h3F) r_cnt <= r_cnt + 6'd1;
            r_dst_uc_bad <= r_dst_uc_bad | w_uc_miss;
            r_dst_bc_bad <= r_dst_bc_bad | w_bc_miss;
            r_err        <= r_err | w_byte_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_req <= 1'b0;
            r_sha    <= 48'd0;
            r_spa    <= 32'd0;
        end else if (r_state == S_ARP_DATA && gmii_rx_dv) begin
            if (r_cnt == 6'd7)                     r_op_req <= (gmii_rxd == ARP_OP_REQ[7:0]);
            if (r_cnt >= 6'd8  && r_cnt <= 6'd13)  r_sha    <= {r_sha[39:0], gmii_rxd};
            if (r_cnt >= 6'd14 && r_cnt <= 6'd17)  r_spa    <= {r_spa[23:0], gmii_rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arp_rx_done <= 1'b0;
            arp_rx_op   <= 1'b0;
            src_mac     <= 48'd0;
            src_ip      <= 32'd0;
        end else begin
            arp_rx_done <= w_accept;
            if (w_accept) begin
                arp_rx_op <= r_op_req;
                src_mac   <= r_sha;
                src_ip    <= r_spa;
            end
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// Self-checking bench for arp_rx: table of frames plus truncation, reset and back-to-back sequences.
module tb_arp_rx;

    localparam logic [47:0] B_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] B_IP  = 32'hC0A8_010A;

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        arp_rx_done;
    logic        arp_rx_op;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    arp_rx #(.BOARD_MAC(B_MAC), .BOARD_IP(B_IP)) dut (
        .clk         (clk),
        .rst         (rst),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .arp_rx_done (arp_rx_done),
        .arp_rx_op   (arp_rx_op),
        .src_mac     (src_mac),
        .src_ip      (src_ip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] etype;
        logic [7:0]  sfd;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        bit          exp_acc;
    } vec_t;

    typedef struct {
        logic        op;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;

    localparam int TPA3_IDX = 8 + 14 + 27;

    vec_t        vecs [8];
    exp_t        sb [$];
    logic [7:0]  fb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          prev_done = 1'b0;
    logic        m_op  = 1'b0;
    logic [47:0] m_mac = 48'd0;
    logic [31:0] m_ip  = 32'd0;

    // Advance one clock and check any done pulse against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (arp_rx_done === 1'b1) begin
            if (prev_done) begin
                n_tests++; n_fail++;
                $display("FAIL done_twice: done high two cycles in a row at %0t", $time);
            end
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got pulse op=%0b mac=%h ip=%h, want none", arp_rx_op, src_mac, src_ip);
            end else begin
                e = sb.pop_front();
                if ({arp_rx_op, src_mac, src_ip} !== {e.op, e.mac, e.ip}) begin
                    n_fail++;
                    $display("FAIL pulse_data: got op=%0b mac=%h ip=%h, want op=%0b mac=%h ip=%h",
                             arp_rx_op, src_mac, src_ip, e.op, e.mac, e.ip);
                end
            end
        end
        prev_done = (arp_rx_done === 1'b1);
    endtask

    task automatic push_field(input logic [47:0] val, input int nbytes);
        for (int k = nbytes - 1; k >= 0; k--) fb.push_back(8'(val >> (8 * k)));
    endtask

    task automatic check_held(input string name);
        n_tests++;
        if ({arp_rx_op, src_mac, src_ip} !== {m_op, m_mac, m_ip}) begin
            n_fail++;
            $display("FAIL %s: got op=%0b mac=%h ip=%h, want op=%0b mac=%h ip=%h",
                     name, arp_rx_op, src_mac, src_ip, m_op, m_mac, m_ip);
        end
    endtask

    // Drive one frame; limit >= 0 drops dv before byte index limit (counted from first preamble byte).
    task automatic send_frame(input vec_t v, input int limit, input int pad, input int ipg, input string name);
        exp_t e;
        bit   exp;
        int   n;
        fb.delete();
        for (int i = 0; i < 7; i++) fb.push_back(8'h55);
        fb.push_back(v.sfd);
        push_field(v.dst, 6);
        push_field(48'h02_00_00_00_00_01, 6);
        push_field({32'd0, v.etype}, 2);
        push_field(48'h0001_0800_0604, 6);
        push_field({32'd0, v.oper}, 2);
        push_field(v.sha, 6);
        push_field({16'd0, v.spa}, 4);
        push_field(48'd0, 6);
        push_field({16'd0, v.tpa}, 4);
        for (int i = 0; i < pad; i++) fb.push_back(8'h00);
        push_field(48'h0000_DEAD_BEEF, 4);

        exp = v.exp_acc && (limit < 0);
        if (exp) begin
            e.op = (v.oper == 16'h0001); e.mac = v.sha; e.ip = v.spa;
            sb.push_back(e);
        end
        n = (limit >= 0) ? limit : fb.size();
        for (int i = 0; i < n; i++) begin
            gmii_rx_dv = 1'b1;
            gmii_rxd   = fb[i];
            tick();
            if (i == TPA3_IDX) begin
                n_tests++;
                if (arp_rx_done !== exp) begin
                    n_fail++;
                    $display("FAIL %s_latency: done=%b one edge after last TPA byte, want %b", name, arp_rx_done, exp);
                end
            end
        end
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        for (int i = 0; i < ipg; i++) tick();
        if (exp) begin
            m_op = e.op; m_mac = e.mac; m_ip = e.ip;
        end
    endtask

    initial begin
        vecs[0] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 8'hD5, 16'h0001, 48'h02AA_BBCC_DDEE, 32'hC0A8_0164, B_IP, 1'b1};
        vecs[1] = '{B_MAC,             16'h0806, 8'hD5, 16'h0002, 48'h0212_3456_789A, 32'hC0A8_0102, B_IP, 1'b1};
        vecs[2] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 8'hD5, 16'h0001, 48'h02DE_AD00_0001, 32'hC0A8_0103, 32'hC0A8_010B, 1'b0};
        vecs[3] = '{B_MAC,             16'h0800, 8'hD5, 16'h0001, 48'h02DE_AD00_0002, 32'hC0A8_0104, B_IP, 1'b0};
        vecs[4] = '{48'h0011_2233_4456, 16'h0806, 8'hD5, 16'h0001, 48'h02DE_AD00_0003, 32'hC0A8_0105, B_IP, 1'b0};
        vecs[5] = '{B_MAC,             16'h0806, 8'hD4, 16'h0001, 48'h02DE_AD00_0004, 32'hC0A8_0106, B_IP, 1'b0};
        vecs[6] = '{B_MAC,             16'h0806, 8'hD5, 16'h0003, 48'h02DE_AD00_0005, 32'hC0A8_0107, B_IP, 1'b0};
        vecs[7] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 8'hD5, 16'h0002, 48'h0A0B_0C0D_0E0F, 32'hC0A8_01FE, B_IP, 1'b1};

        rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
        tick(); tick();
        check_held("reset_outputs");
        n_tests++;
        if (arp_rx_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", arp_rx_done);
        end
        rst = 1'b0;
        tick(); tick();

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i], -1, 18, 12, $sformatf("vec%0d", i));
            check_held($sformatf("vec%0d_outputs", i));
        end

        // dv drops before ARP byte 15, valid frame one idle cycle later
        send_frame(vecs[0], 8 + 14 + 15, 0, 1, "trunc");
        check_held("trunc_outputs");
        send_frame(vecs[1], -1, 18, 12, "after_trunc");
        check_held("after_trunc_outputs");

        // reset while in the Ethernet header
        send_frame(vecs[7], 8 + 5, 0, 0, "rst_mid");
        rst = 1'b1;
        tick();
        m_op = 1'b0; m_mac = 48'd0; m_ip = 32'd0;
        check_held("rst_mid_outputs");
        rst = 1'b0;
        tick(); tick();
        check_held("rst_mid_idle");
        send_frame(vecs[0], -1, 18, 12, "after_rst");
        check_held("after_rst_outputs");

        // back-to-back request then reply
        send_frame(vecs[7], -1, 18, 12, "b2b_a");
        check_held("b2b_a_outputs");
        vecs[0].oper = 16'h0001;
        vecs[1].oper = 16'h0002;
        send_frame(vecs[0], -1, 18, 12, "b2b_req");
        check_held("b2b_req_outputs");
        send_frame(vecs[1], -1, 18, 12, "b2b_rep");
        check_held("b2b_rep_outputs");

        repeat (4) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: %0d expected pulses never seen, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
